trap_controller: RTL and testbench

- Sequences exception handling around the CSR block. Arbitrates simultaneous exception reports from N_SRC pipeline sources by program age (ROB-relative tag), flushes the pipeline, writes EPC/CAUSE into the CSR file, and redirects fetch to the handler.
- On mret, redirects fetch back to the saved EPC. Gates software CSR writes so they never collide with the trap write.

---
 rtl/trap_pkg.sv | 32 +++
 rtl/trap_age_arbiter.sv | 50 +++++
 rtl/trap_controller.sv | 160 ++++++++++++++++
 tb/tb_trap_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trap_pkg
//  Description : Shared types and constants for the trap controller and the
//                CSR file it feeds. Holds the sequencer state encoding, the
//                cause codes the controller acts on, and the CSR addresses.
//  Revision    : 1.0  initial release
// ============================================================================
package trap_pkg;

    // Trap sequencer states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLUSH    = 3'd1,
        SAVE     = 3'd2,
        REDIRECT = 3'd3,
        HANDLER  = 3'd4,
        RETURN   = 3'd5
    } trap_state_t;

    // Cause codes
    localparam logic [4:0] CAUSE_MISALIGN = 5'd0;
    localparam logic [4:0] CAUSE_ILLEGAL  = 5'd2;
    localparam logic [4:0] CAUSE_ECALL    = 5'd11;

    // CSR addresses shared with the CSR file
    localparam logic [11:0] WRITE = 12'h000;
    localparam logic [11:0] CAUSE = 12'h001;
    localparam logic [11:0] EPC   = 12'h002;

endpackage : trap_pkg
`default_nettype wire

// File: rtl/trap_age_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : trap_age_arbiter
//  Description : Combinational oldest-first arbiter. Each valid source's age
//                is its ROB tag minus the ROB head, modulo 2^TAG_W. The valid
//                source with the smallest age wins; ties go to the lowest
//                index.
//  Ports       : exc_valid  - per-source request
//                exc_tag    - per-source ROB tag, source i at [TAG_W*i +: TAG_W]
//                rob_head   - current ROB head tag
//                winner     - index of the winning source
//                any_valid  - at least one source is requesting
//  Revision    : 1.0  initial release
// ============================================================================
module trap_age_arbiter #(
    parameter  int N_SRC = 4,
    parameter  int TAG_W = 5,
    localparam int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0]       exc_valid,
    input  logic [N_SRC*TAG_W-1:0] exc_tag,
    input  logic [TAG_W-1:0]       rob_head,
    output logic [IDX_W-1:0]       winner,
    output logic                   any_valid
);

    logic [TAG_W-1:0] w_age;
    logic [TAG_W-1:0] w_best_age;

    always_comb begin
        w_age      = '0;
        w_best_age = '1;
        winner     = '0;
        any_valid  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (exc_valid[i]) begin
                // Unsigned subtraction wraps, giving the modulo age directly
                w_age = exc_tag[TAG_W*i +: TAG_W] - rob_head;
                // Strict less-than keeps the lower index on equal ages
                if (!any_valid || (w_age < w_best_age)) begin
                    w_best_age = w_age;
                    winner     = IDX_W'(i);
                end
                any_valid = 1'b1;
            end
        end
    end

endmodule : trap_age_arbiter
`default_nettype wire

// File: rtl/trap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : trap_controller
//  Description : Sequences exception entry and mret return around the CSR
//                file. Picks the oldest reporting source, flushes the
//                pipeline for FLUSH_CYCLES cycles, writes EPC/CAUSE, redirects
//                fetch to the handler and, on mret, back to the saved EPC
//                (EPC+4 for ecall). Software CSR writes are held off while
//                the trap write is pending.
//  Ports       : clk, reset (async, active low)
//                exc_valid/exc_pc/exc_cause/exc_tag - per-source reports
//                rob_head   - ROB head tag for age comparison
//                mret_valid - mret commit pulse
//                epc_in     - EPC read back from the CSR file
//                sw_csr_req/sw_csr_gnt - software CSR write handshake
//                exc_ack    - one-hot accept of the winning source
//                exception_sig/exception_pc/exception_cause - CSR write
//                flush, pc_redirect_valid, pc_redirect, busy
//  Revision    : 1.0  initial release
// ============================================================================
module trap_controller
    import trap_pkg::*;
#(
    parameter int          N_SRC        = 4,
    parameter int          TAG_W        = 5,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0100
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SRC-1:0]       exc_valid,
    input  logic [N_SRC*32-1:0]    exc_pc,
    input  logic [N_SRC*5-1:0]     exc_cause,
    input  logic [N_SRC*TAG_W-1:0] exc_tag,
    input  logic [TAG_W-1:0]       rob_head,
    input  logic                   mret_valid,
    input  logic [31:0]            epc_in,
    input  logic                   sw_csr_req,
    output logic                   sw_csr_gnt,
    output logic [N_SRC-1:0]       exc_ack,
    output logic                   exception_sig,
    output logic [31:0]            exception_pc,
    output logic [4:0]             exception_cause,
    output logic                   flush,
    output logic                   pc_redirect_valid,
    output logic [31:0]            pc_redirect,
    output logic                   busy
);

    localparam int IDX_W = $clog2(N_SRC);
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    trap_state_t        r_state;
    trap_state_t        w_state_next;
    logic [31:0]        r_pc;
    logic [4:0]         r_cause;
    logic [IDX_W-1:0]   r_src;
    logic [CNT_W-1:0]   r_cnt;

    logic [IDX_W-1:0]   w_winner;
    logic               w_any_valid;

    trap_age_arbiter #(
        .N_SRC (N_SRC),
        .TAG_W (TAG_W)
    ) u_arb (
        .exc_valid (exc_valid),
        .exc_tag   (exc_tag),
        .rob_head  (rob_head),
        .winner    (w_winner),
        .any_valid (w_any_valid)
    );

    // ------------------------------------------------------------------------
    // State register and trap context
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_cause <= '0;
            r_src   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_any_valid) begin
                r_pc    <= exc_pc[32*w_winner +: 32];
                r_cause <= exc_cause[5*w_winner +: 5];
                r_src   <= w_winner;
                r_cnt   <= CNT_W'(FLUSH_CYCLES);
            end else if (r_state == FLUSH) begin
                r_cnt   <= r_cnt - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_any_valid) w_state_next = FLUSH;
            FLUSH:    if (r_cnt == CNT_W'(1)) w_state_next = SAVE;
            SAVE:     w_state_next = REDIRECT;
            REDIRECT: w_state_next = HANDLER;
            HANDLER:  if (mret_valid) w_state_next = RETURN;
            RETURN:   w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs, decoded from state and latched context only
    // ------------------------------------------------------------------------
    always_comb begin
        exc_ack           = '0;
        exception_sig     = 1'b0;
        exception_pc      = '0;
        exception_cause   = '0;
        flush             = 1'b0;
        pc_redirect_valid = 1'b0;
        pc_redirect       = '0;
        busy              = (r_state != IDLE);
        case (r_state)
            FLUSH: begin
                flush = 1'b1;
                // The counter still holds its load value only in the first
                // flush cycle, so the ack is a single-cycle pulse
                if (r_cnt == CNT_W'(FLUSH_CYCLES)) begin
                    for (int i = 0; i < N_SRC; i++) begin
                        exc_ack[i] = (r_src == IDX_W'(i));
                    end
                end
            end
            SAVE: begin
                exception_sig   = 1'b1;
                exception_pc    = r_pc;
                exception_cause = r_cause;
            end
            REDIRECT: begin
                pc_redirect_valid = 1'b1;
                pc_redirect       = HANDLER_ADDR;
            end
            RETURN: begin
                flush             = 1'b1;
                pc_redirect_valid = 1'b1;
                // ecall returns past the trapping instruction
                pc_redirect       = (r_cause == CAUSE_ECALL) ? (epc_in + 32'd4) : epc_in;
            end
            default: ;
        endcase
    end

    // Software CSR writes are held off while the trap write is in flight;
    // reset forces the grant low so every output reads zero in reset
    assign sw_csr_gnt = sw_csr_req && reset && (r_state != FLUSH) && (r_state != SAVE);

endmodule : trap_controller
`default_nettype wire

// File: tb/tb_trap_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trap_controller
//  Description : Directed self-checking bench for trap_controller with the
//                default parameters (4 sources, 5-bit tags, 2 flush cycles,
//                handler at 0x100).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_trap_controller;

    localparam int N_SRC = 4;
    localparam int TAG_W = 5;

    logic                   clk;
    logic                   reset;
    logic [N_SRC-1:0]       exc_valid;
    logic [N_SRC*32-1:0]    exc_pc;
    logic [N_SRC*5-1:0]     exc_cause;
    logic [N_SRC*TAG_W-1:0] exc_tag;
    logic [TAG_W-1:0]       rob_head;
    logic                   mret_valid;
    logic [31:0]            epc_in;
    logic                   sw_csr_req;
    logic                   sw_csr_gnt;
    logic [N_SRC-1:0]       exc_ack;
    logic                   exception_sig;
    logic [31:0]            exception_pc;
    logic [4:0]             exception_cause;
    logic                   flush;
    logic                   pc_redirect_valid;
    logic [31:0]            pc_redirect;
    logic                   busy;

    int n_vec = 0;
    int n_err = 0;

    trap_controller #(
        .N_SRC        (N_SRC),
        .TAG_W        (TAG_W),
        .FLUSH_CYCLES (2),
        .HANDLER_ADDR (32'h0000_0100)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .exc_valid         (exc_valid),
        .exc_pc            (exc_pc),
        .exc_cause         (exc_cause),
        .exc_tag           (exc_tag),
        .rob_head          (rob_head),
        .mret_valid        (mret_valid),
        .epc_in            (epc_in),
        .sw_csr_req        (sw_csr_req),
        .sw_csr_gnt        (sw_csr_gnt),
        .exc_ack           (exc_ack),
        .exception_sig     (exception_sig),
        .exception_pc      (exception_pc),
        .exception_cause   (exception_cause),
        .flush             (flush),
        .pc_redirect_valid (pc_redirect_valid),
        .pc_redirect       (pc_redirect),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock, then settle past the edge before looking at outputs
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic v, input logic [31:0] pc,
                           input logic [4:0] cause, input logic [TAG_W-1:0] tag);
        exc_valid[i]              = v;
        exc_pc[32*i +: 32]        = pc;
        exc_cause[5*i +: 5]       = cause;
        exc_tag[TAG_W*i +: TAG_W] = tag;
    endtask

    // Trap write and software CSR grant must never coincide
    always @(negedge clk) begin
        if (reset) chk("sig_gnt_excl", {63'd0, exception_sig & sw_csr_gnt}, 64'd0);
    end

    initial begin
        reset      = 1'b0;
        exc_valid  = '0;
        exc_pc     = '0;
        exc_cause  = '0;
        exc_tag    = '0;
        rob_head   = '0;
        mret_valid = 1'b0;
        epc_in     = '0;
        sw_csr_req = 1'b1;

        // ---------------- reset state ----------------
        #12;
        chk("rst_busy",  busy, 0);
        chk("rst_flush", flush, 0);
        chk("rst_ack",   exc_ack, 0);
        chk("rst_sig",   exception_sig, 0);
        chk("rst_pcrv",  pc_redirect_valid, 0);
        chk("rst_pcr",   pc_redirect, 0);
        chk("rst_gnt",   sw_csr_gnt, 0);
        reset = 1'b1;
        step();
        chk("idle_gnt", sw_csr_gnt, 1);

        // ---------------- mret in IDLE ignored ----------------
        mret_valid = 1'b1;
        step();
        mret_valid = 1'b0;
        chk("mret_idle_busy", busy, 0);
        chk("mret_idle_pcrv", pc_redirect_valid, 0);

        // ---------------- single source ----------------
        set_src(1, 1'b1, 32'h40, 5'd2, 5'd3);
        step();                                   // FLUSH 1
        chk("s1_ack",   exc_ack, 4'b0010);
        chk("s1_flush", flush, 1);
        chk("s1_busy",  busy, 1);
        chk("s1_gnt",   sw_csr_gnt, 0);
        set_src(1, 1'b0, 32'h0, 5'd0, 5'd0);
        step();                                   // FLUSH 2
        chk("s1_ack2",   exc_ack, 0);
        chk("s1_flush2", flush, 1);
        chk("s1_gnt2",   sw_csr_gnt, 0);
        step();                                   // SAVE
        chk("s1_sig",    exception_sig, 1);
        chk("s1_epc",    exception_pc, 32'h40);
        chk("s1_cause",  exception_cause, 5'd2);
        chk("s1_flush3", flush, 0);
        chk("s1_gnt3",   sw_csr_gnt, 0);
        step();                                   // REDIRECT
        chk("s1_pcrv",  pc_redirect_valid, 1);
        chk("s1_pcr",   pc_redirect, 32'h100);
        chk("s1_epc0",  exception_pc, 0);
        chk("s1_gnt4",  sw_csr_gnt, 1);
        step();                                   // HANDLER
        chk("s1_hbusy", busy, 1);
        chk("s1_hpcrv", pc_redirect_valid, 0);
        chk("s1_hgnt",  sw_csr_gnt, 1);

        // new exception during HANDLER is ignored
        set_src(3, 1'b1, 32'h80, 5'd11, 5'd9);
        step();
        chk("h_noack", exc_ack, 0);
        chk("h_busy",  busy, 1);
        chk("h_flush", flush, 0);

        // mret returns to EPC (cause 2, no +4)
        epc_in     = 32'h200;
        mret_valid = 1'b1;
        step();                                   // RETURN
        mret_valid = 1'b0;
        chk("r1_flush", flush, 1);
        chk("r1_pcrv",  pc_redirect_valid, 1);
        chk("r1_pcr",   pc_redirect, 32'h200);
        chk("r1_ack",   exc_ack, 0);
        step();                                   // IDLE
        chk("r1_idle_busy", busy, 0);
        chk("r1_idle_ack",  exc_ack, 0);
        step();                                   // FLUSH for pending src3
        chk("p_ack", exc_ack, 4'b1000);
        set_src(3, 1'b0, 32'h0, 5'd0, 5'd0);
        step();                                   // FLUSH 2
        step();                                   // SAVE
        chk("p_epc",   exception_pc, 32'h80);
        chk("p_cause", exception_cause, 5'd11);
        step();                                   // REDIRECT
        step();                                   // HANDLER
        epc_in     = 32'h200;
        mret_valid = 1'b1;
        step();                                   // RETURN (ecall)
        mret_valid = 1'b0;
        chk("r2_pcr",   pc_redirect, 32'h204);
        chk("r2_flush", flush, 1);
        step();                                   // IDLE
        chk("r2_busy", busy, 0);

        // ---------------- age arbitration with wrap ----------------
        rob_head = 5'd30;
        set_src(0, 1'b1, 32'h1000, 5'd0, 5'd2);   // age 4
        set_src(2, 1'b1, 32'h2000, 5'd2, 5'd31);  // age 1
        step();
        chk("wrap_ack", exc_ack, 4'b0100);
        set_src(2, 1'b0, 32'h0, 5'd0, 5'd0);
        step();
        step();                                   // SAVE
        chk("wrap_epc", exception_pc, 32'h2000);
        step();
        step();                                   // HANDLER
        epc_in     = 32'h300;
        mret_valid = 1'b1;
        step();                                   // RETURN
        mret_valid = 1'b0;
        step();                                   // IDLE
        step();                                   // FLUSH for src0
        chk("src0_ack", exc_ack, 4'b0001);
        set_src(0, 1'b0, 32'h0, 5'd0, 5'd0);
        step();
        step();                                   // SAVE
        chk("src0_epc",   exception_pc, 32'h1000);
        chk("src0_cause", exception_cause, 5'd0);
        step();
        step();                                   // HANDLER
        epc_in     = 32'hFFFF_FFFC;
        mret_valid = 1'b1;
        step();                                   // RETURN, cause 0
        mret_valid = 1'b0;
        chk("r3_pcr", pc_redirect, 32'hFFFF_FFFC);
        step();                                   // IDLE

        // ---------------- equal tags: lowest index wins ----------------
        set_src(0, 1'b1, 32'h500, 5'd2, 5'd5);
        set_src(2, 1'b1, 32'h600, 5'd2, 5'd5);
        step();
        chk("tie_ack", exc_ack, 4'b0001);

        // ---------------- async reset mid-FLUSH ----------------
        #2;
        reset = 1'b0;
        #1;
        chk("ar_flush", flush, 0);
        chk("ar_busy",  busy, 0);
        chk("ar_ack",   exc_ack, 0);
        chk("ar_gnt",   sw_csr_gnt, 0);
        exc_valid = '0;
        #2;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("post_sig",  exception_sig, 0);
            chk("post_busy", busy, 0);
            chk("post_pcrv", pc_redirect_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule : tb_trap_controller
`default_nettype wire
